// File: rtl/serial_to_parallel_rx_if.sv
// Parallel-side bundle of the serial link receiver.
//   data_in    : serial bit stream, MSB of each word first
//   data_out   : last received non-comma word, held between updates
//   valid_out  : one-cycle strobe, data_out updated this cycle
//   active_out : high while the receiver is locked (ACTIVE)
// The master modport is the link/parallel-side environment; the slave
// modport is the receiver itself.
interface serial_to_parallel_rx_if #(
  parameter int WIDTH = 8
);
  logic             data_in;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             active_out;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  active_out
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output active_out
  );
endinterface

// File: rtl/serial_to_parallel_rx.sv
// Serial-to-parallel receiver with comma-based word alignment.
// Deserialises an MSB-first bit stream, hunts for the comma character on
// every bit offset, confirms alignment with a run of COMMA_COUNT aligned
// commas, then presents every non-comma word with a one-cycle strobe.
// Ports:
//   clk     : bit-rate clock, rising edge
//   reset_L : asynchronous active-low reset, clears all state
//   link    : slave side of serial_to_parallel_rx_if
//             (data_in in; data_out, valid_out, active_out out)
// WIDTH must be 8.
module serial_to_parallel_rx #(
  parameter int             WIDTH       = 8,
  parameter logic [7:0]     COMMA       = 8'hBC,
  parameter int             COMMA_COUNT = 4
) (
  input logic                      clk,
  input logic                      reset_L,
  serial_to_parallel_rx_if.slave   link
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_TARGET = 4'(COMMA_COUNT);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [3:0]       comma_cnt_q, comma_cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] w;
  logic             boundary;
  logic             is_comma;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= SEARCH;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
    end
  end

  always_comb begin
    // The word under test includes the bit being sampled on this edge,
    // so a complete word is registered with no extra cycle of latency.
    w        = {sr_q[WIDTH-2:0], link.data_in};
    boundary = (bit_cnt_q == 3'd7);
    is_comma = (w == COMMA);

    state_d     = state_q;
    sr_d        = w;
    bit_cnt_d   = bit_cnt_q;
    comma_cnt_d = comma_cnt_q;
    data_d      = data_q;
    valid_d     = 1'b0;

    case (state_q)
      SEARCH: begin
        // Sliding window: any bit offset may hold the comma. Clearing
        // bit_cnt here puts the next boundary exactly 8 edges later.
        bit_cnt_d = 3'd0;
        if (is_comma) begin
          comma_cnt_d = 4'd1;
          state_d     = (CNT_TARGET == 4'd1) ? ACTIVE : ALIGN;
        end
      end

      ALIGN: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          if (is_comma) begin
            comma_cnt_d = comma_cnt_q + 4'd1;
            if (comma_cnt_q + 4'd1 == CNT_TARGET) begin
              state_d = ACTIVE;
            end
          end else begin
            // Broken run: hunt again from the next edge; the bits of this
            // word are not re-scanned.
            comma_cnt_d = 4'd0;
            state_d     = SEARCH;
          end
        end
      end

      ACTIVE: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          if (is_comma) begin
            // Idle character: nothing presented, data_out holds.
            valid_d = 1'b0;
          end else begin
            data_d  = w;
            valid_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  assign link.data_out   = data_q;
  assign link.valid_out  = valid_q;
  assign link.active_out = (state_q == ACTIVE);

endmodule
